// File: rtl/pll_sup_pkg.sv
// Shared types and reset constants for the PLL supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RST_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    APPLY,
    FAULT
  } state_t;

  localparam logic [3:0] PSDA_INIT = 4'b0000;
  localparam logic [3:0] DUTY_INIT = 4'b1000;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous status inputs.
module sync_2ff #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] sync_p0;
  logic [DATA_W-1:0] sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/pll_supervisor.sv
// Sequences rPLL reset and lock qualification, gates the system reset, and
// applies runtime phase/duty updates with optional relock.
module pll_supervisor
  import pll_sup_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65535,
  parameter int RESET_PULSE_CYCLES  = 16,
  parameter int SETTLE_CYCLES       = 64,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [3:0] cfg_psda,
  input  logic [3:0] cfg_dutyda,
  input  logic       cfg_relock,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [3:0] pll_psda,
  output logic [3:0] pll_dutyda,
  output logic       sys_rst,
  output logic       locked,
  output logic       fault
);

  localparam int MAX_P = max_of(max_of(LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES),
                                max_of(RESET_PULSE_CYCLES, SETTLE_CYCLES));
  localparam int CNT_W = $clog2(MAX_P) + 1;
  localparam int RTY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] LOAD_RST = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_TMO = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_STB = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_SET = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [RTY_W-1:0]   retries, retries_d;
  logic               lock_s;
  logic               accept;
  logic               pll_reset_d, sys_rst_d, locked_d, fault_d;

  // Counter is loaded with N-1 so a state lasts exactly N cycles.
  function automatic logic [CNT_W-1:0] load_for(input state_t s);
    case (s)
      RST_PLL:   return LOAD_RST;
      WAIT_LOCK: return LOAD_TMO;
      STABLE:    return LOAD_STB;
      APPLY:     return LOAD_SET;
      default:   return '0;
    endcase
  endfunction

  sync_2ff #(.DATA_W(1)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  assign cfg_ready = (state == RUN && lock_s) || (state == FAULT);
  assign accept    = cfg_valid && cfg_ready;

  always_comb begin
    state_d   = state;
    retries_d = retries;
    case (state)
      RST_PLL: begin
        if (cnt == '0) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
        end else if (cnt == '0) begin
          retries_d = retries + RTY_W'(1);
          state_d   = (retries_d == RTY_MAX) ? FAULT : RST_PLL;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt == '0) begin
          state_d   = RUN;
          retries_d = '0;
        end
      end
      RUN: begin
        if (!lock_s) state_d = RST_PLL;
        else if (cfg_valid) state_d = cfg_relock ? RST_PLL : APPLY;
      end
      APPLY: begin
        if (!lock_s) state_d = RST_PLL;
        else if (cnt == '0) state_d = RUN;
      end
      FAULT: begin
        if (cfg_valid) begin
          state_d   = RST_PLL;
          retries_d = '0;
        end
      end
      default: state_d = RST_PLL;
    endcase
  end

  // Outputs decode the next state so they switch on the same edge as the state.
  always_comb begin
    pll_reset_d = (state_d == RST_PLL) || (state_d == FAULT);
    locked_d    = (state_d == RUN) || (state_d == APPLY);
    sys_rst_d   = !locked_d;
    fault_d     = (state_d == FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RST_PLL;
      cnt        <= LOAD_RST;
      retries    <= '0;
      pll_reset  <= 1'b1;
      sys_rst    <= 1'b1;
      locked     <= 1'b0;
      fault      <= 1'b0;
      pll_psda   <= PSDA_INIT;
      pll_dutyda <= DUTY_INIT;
    end else begin
      state     <= state_d;
      retries   <= retries_d;
      pll_reset <= pll_reset_d;
      sys_rst   <= sys_rst_d;
      locked    <= locked_d;
      fault     <= fault_d;
      if (state_d != state) cnt <= load_for(state_d);
      else if (cnt != '0)   cnt <= cnt - CNT_W'(1);
      if (accept) begin
        pll_psda   <= cfg_psda;
        pll_dutyda <= cfg_dutyda;
      end
    end
  end

endmodule

// File: doc/pll_supervisor.md
# pll_supervisor

Supervises the board rPLL that generates the acquisition and PSRAM clocks from the 27 MHz input. Runs on the PLL reference clock, sequences PLL reset and lock qualification, and holds the downstream system reset until lock is stable. Applies runtime phase (PSDA) and duty (DUTYDA) updates through a valid/ready port, recovers from lock loss, and flags a sticky fault after repeated lock timeouts.

## Interface
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronised-lock cycles required before release.
- `LOCK_TIMEOUT_CYCLES`, default 65535: maximum wait for lock after PLL reset release.
- `RESET_PULSE_CYCLES`, default 16: `pll_reset` pulse width.
- `SETTLE_CYCLES`, default 64: hold-off after a phase/duty change made without relock.
- `MAX_RETRIES`, default 3: number of timeouts before entering FAULT.
- `clk` in 1: 27 MHz reference clock; the same net drives the PLL `CLKIN`.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `cfg_valid` in 1: configuration request.
- `cfg_ready` out 1: request accepted when `cfg_valid && cfg_ready` on a rising edge.
- `cfg_psda` in 4: phase setting.
- `cfg_dutyda` in 4: duty setting.
- `cfg_relock` in 1: 1 forces a full PLL reset and relock after the update.
- `pll_lock` in 1: raw PLL `LOCK`, asynchronous to `clk`.
- `pll_reset` out 1: drives PLL `RESET`.
- `pll_psda` out 4: drives PLL `PSDA`.
- `pll_dutyda` out 4: drives PLL `DUTYDA`.
- `sys_rst` out 1: active-high reset for the downstream design.
- `locked` out 1: 1 only in RUN and APPLY.
- `fault` out 1: sticky fault flag.

## Operation
- **Reset values:** `pll_reset`=1, `sys_rst`=1, `locked`=0, `fault`=0, `pll_psda`=4'b0000, `pll_dutyda`=4'b1000, retry count=0, state=RST_PLL.
- **Lock synchronisation:** `pll_lock` passes through a 2-flop synchroniser to give `lock_s`. All decisions use `lock_s`.
- **RST_PLL:** `pll_reset`=1, `sys_rst`=1. Leave after `RESET_PULSE_CYCLES` cycles for WAIT_LOCK.
- **WAIT_LOCK:** `pll_reset`=0.
  - `lock_s`=1 goes to STABLE.
  - After `LOCK_TIMEOUT_CYCLES` cycles without lock, increment retries. If retries == `MAX_RETRIES`, go to FAULT; otherwise go to RST_PLL.
- **STABLE:** count consecutive `lock_s`=1 cycles.
  - `lock_s`=0 returns to WAIT_LOCK with the timeout restarted.
  - At count `LOCK_STABLE_CYCLES`, go to RUN and clear retries.
- **RUN:** `sys_rst`=0, `locked`=1.
  - `lock_s`=0 goes to RST_PLL, with `sys_rst`=1 from the next edge (lock loss).
  - A cfg handshake latches `cfg_psda`/`cfg_dutyda` into `pll_psda`/`pll_dutyda` on the same edge. Then:
    - `cfg_relock`=1 goes to RST_PLL with `sys_rst`=1.
    - Otherwise go to APPLY.
- **APPLY:** `sys_rst` stays 0 and `cfg_ready`=0. Return to RUN after `SETTLE_CYCLES` cycles. `lock_s`=0 is handled as a lock loss.
- **FAULT:** `pll_reset`=1, `sys_rst`=1, `fault`=1.
  - A cfg handshake latches the settings, clears `fault` and retries, and goes to RST_PLL.
- **`cfg_ready`** is combinational: `(state==RUN && lock_s) || state==FAULT`. Lock loss therefore beats a simultaneous request, and the request is not accepted.
- **Shared counter:** one down-counter serves every timed state. Width is `$clog2` of the largest parameter, plus 1. It reloads on every state entry and never wraps.
- **`rst` mid-operation:** all outputs return to their reset values immediately, including `pll_psda`/`pll_dutyda`.

## Timing
- `lock_s` lags `pll_lock` by 2 clocks. A state change acting on it lands on the 3rd edge.
- After `rst` falls, `pll_reset` stays high for exactly `RESET_PULSE_CYCLES` clocks.
- `sys_rst` falls on the edge `LOCK_STABLE_CYCLES`+3 clocks after `pll_lock` rises (steady lock).
- `sys_rst` rises 3 clocks after `pll_lock` falls in RUN or APPLY.
- `pll_psda`/`pll_dutyda` change on the handshake edge. There are no intermediate values.
- All outputs are registered except `cfg_ready`.

## Structure
- **Package `pll_sup_pkg`:** state enum (RST_PLL, WAIT_LOCK, STABLE, RUN, APPLY, FAULT) and the reset constants `PSDA_INIT`=4'b0000, `DUTY_INIT`=4'b1000.
- **Sub-module `sync_2ff`:** lock synchroniser, reusable for other async status inputs.

## Test plan
Test parameters: `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32, `RESET_PULSE_CYCLES`=4, `SETTLE_CYCLES`=4, `MAX_RETRIES`=2.
- **Power-up:** release `rst`, raise `pll_lock` 10 clocks later → `pll_reset` high for 4 clocks; `sys_rst` falls 11 clocks after the lock edge; `locked`=1.
- **Lock glitch in STABLE:** drop `pll_lock` for 1 clock after 5 stable cycles → the count restarts and `sys_rst` is released 11 clocks after the lock returns.
- **Timeout and fault:** `pll_lock` held 0 → two reset pulses of 4 clocks, then `fault`=1, `pll_reset`=1, `cfg_ready`=1. A cfg handshake clears `fault` and restarts the sequence.
- **Phase update without relock:** in RUN, handshake psda=4'b0101, duty=4'b0110, relock=0 → outputs update on that edge; `cfg_ready`=0 for 4 clocks; `sys_rst` stays 0.
- **Relock update plus lock loss:**
  - Handshake with relock=1 → `sys_rst`=1 next edge, then a 4-clock `pll_reset`.
  - Lock drop in RUN at the same cycle as `cfg_valid` → no accept, `sys_rst` rises 3 clocks after the drop.
- **Async reset mid-APPLY:** assert `rst` → all outputs at reset values before the next edge; psda=0000, duty=1000.
